// File: rtl/ma_dot_sequencer.sv
// Dot-product job sequencer for the shared 18x18 MAC core: fetches operand pairs,
// schedules the accumulator reload, waits out read/MAC latency and returns the result.
module ma_dot_sequencer #(
  parameter int AW      = 10,
  parameter int DW      = 18,
  parameter int PW      = 96,
  parameter int LEN_W   = 11,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [AW-1:0]        job_base_a,
  input  logic [AW-1:0]        job_base_b,
  input  logic [LEN_W-1:0]     job_len,
  input  logic signed [PW-1:0] job_init,
  output logic                 rd_en,
  output logic [AW-1:0]        rd_addr_a,
  output logic [AW-1:0]        rd_addr_b,
  input  logic signed [DW-1:0] rd_data_a,
  input  logic signed [DW-1:0] rd_data_b,
  output logic signed [DW-1:0] mac_a,
  output logic signed [DW-1:0] mac_b,
  output logic                 mac_reload,
  output logic signed [PW-1:0] mac_acc_init,
  input  logic signed [PW-1:0] mac_p,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic signed [PW-1:0] res_data,
  output logic                 busy
);

  // Read data -> accumulator register -> MAC output register.
  localparam int DRAIN_CYC = RD_LAT + 1 + MAC_LAT;
  localparam int DCW       = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, DONE} state_t;

  state_t           state;
  logic [AW-1:0]    base_a_q;
  logic [AW-1:0]    base_b_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] k_q;
  logic [LEN_W-1:0] k_nxt;
  logic [DCW-1:0]   drain_cnt;
  logic [RD_LAT-1:0] vld_rd;
  logic             hs;

  assign hs    = job_valid & job_ready;
  assign k_nxt = k_q + LEN_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      job_ready    <= 1'b0;
      busy         <= 1'b0;
      rd_en        <= 1'b0;
      rd_addr_a    <= '0;
      rd_addr_b    <= '0;
      mac_reload   <= 1'b0;
      mac_acc_init <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      base_a_q     <= '0;
      base_b_q     <= '0;
      len_q        <= '0;
      k_q          <= '0;
      drain_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            base_a_q     <= job_base_a;
            base_b_q     <= job_base_b;
            len_q        <= job_len;
            k_q          <= '0;
            mac_acc_init <= job_init;
            mac_reload   <= 1'b1;
            rd_en        <= (job_len != '0);
            rd_addr_a    <= job_base_a;
            rd_addr_b    <= job_base_b;
            job_ready    <= 1'b0;
            busy         <= 1'b1;
            state        <= LOAD;
          end else begin
            job_ready <= 1'b1;
          end
        end
        LOAD: begin
          mac_reload <= 1'b0;
          if (len_q > LEN_W'(1)) begin
            rd_en     <= 1'b1;
            rd_addr_a <= base_a_q + AW'(k_nxt);
            rd_addr_b <= base_b_q + AW'(k_nxt);
            k_q       <= k_nxt;
            state     <= ISSUE;
          end else begin
            rd_en     <= 1'b0;
            drain_cnt <= DCW'(DRAIN_CYC - 1);
            state     <= DRAIN;
          end
        end
        ISSUE: begin
          if (k_q == len_q - LEN_W'(1)) begin
            rd_en     <= 1'b0;
            drain_cnt <= DCW'(DRAIN_CYC - 1);
            state     <= DRAIN;
          end else begin
            rd_addr_a <= base_a_q + AW'(k_nxt);
            rd_addr_b <= base_b_q + AW'(k_nxt);
            k_q       <= k_nxt;
          end
        end
        DRAIN: begin
          // The last product has reached mac_p by the end of the final drain cycle.
          if (drain_cnt == '0) begin
            res_data  <= mac_p;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            drain_cnt <= drain_cnt - DCW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            job_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-valid pipe: marks which cycles carry RAM data for the MAC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_rd <= '0;
    end else begin
      vld_rd[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_rd[i] <= vld_rd[i-1];
      end
    end
  end

  // Zero operands outside valid read slots keep the free-running accumulator unchanged.
  assign mac_a = vld_rd[RD_LAT-1] ? rd_data_a : '0;
  assign mac_b = vld_rd[RD_LAT-1] ? rd_data_b : '0;

endmodule
